// File: rtl/raw10_unpacker_if.sv
// Handshake bundle between a CSI-2 RAW10 payload source and the pixel unpacker.
// The master side drives payload words and accepts pixel groups.
interface raw10_unpacker_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_start;
    logic [15:0] in_word_count;
    logic [1:0]  in_virtual_channel;
    logic [39:0] out_pixels;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [1:0]  out_virtual_channel;
    logic        length_error;

    modport master (
        output in_data, in_valid, in_start, in_word_count, in_virtual_channel, out_ready,
        input  in_ready, out_pixels, out_valid, out_last, out_virtual_channel, length_error
    );

    modport slave (
        input  in_data, in_valid, in_start, in_word_count, in_virtual_channel, out_ready,
        output in_ready, out_pixels, out_valid, out_last, out_virtual_channel, length_error
    );
endinterface

// File: rtl/raw10_unpacker.sv
// RAW10 unpacker: 32-bit CSI-2 payload words in, groups of four 10-bit pixels out.
// An 8-byte FIFO-ordered buffer bridges the 4-byte input and 5-byte output granules.
module raw10_unpacker (
    input  logic            clock,
    input  logic            reset,
    raw10_unpacker_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

    state_t      state, state_next;
    logic [7:0]  byte_buf      [8];
    logic [7:0]  byte_buf_next [8];
    logic [3:0]  occupancy, occupancy_next, kept, base;
    logic [15:0] remaining, remaining_next, take_src;
    logic [1:0]  packet_vc, packet_vc_next;
    logic [2:0]  take;
    logic        in_ready, in_fire, start_fire, abort, append, length_error;
    logic        group_load, group_last;
    logic [39:0] group_pixels;
    logic        out_valid_q, out_last_q;
    logic [39:0] out_pixels_q;
    logic [1:0]  out_vc_q;

    // Pixel n is the full byte Bn extended by its two LSBs packed into B4.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            group_pixels[10*n +: 10] = {byte_buf[n], byte_buf[4][2*n +: 2]};
        end
    end

    // NOTE: every signal below gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        byte_buf_next  = byte_buf;
        remaining_next = remaining;
        packet_vc_next = packet_vc;

        group_load = (occupancy >= 4'd5) && (!out_valid_q || bus.out_ready);
        group_last = ({13'd0, occupancy} + {1'b0, remaining}) < 17'd10;
        kept       = group_load ? occupancy - 4'd5 : occupancy;

        // Readiness uses the occupancy left after this cycle's group leaves, so input and output overlap.
        unique case (state)
            IDLE:    in_ready = 1'b1;
            ACTIVE:  in_ready = (kept <= 4'd4) && (remaining != 16'd0);
            default: in_ready = 1'b0;
        endcase
        if (reset) in_ready = 1'b0;

        in_fire      = bus.in_valid && in_ready;
        start_fire   = in_fire && bus.in_start;
        abort        = start_fire && (state == ACTIVE);
        append       = start_fire || (in_fire && (state == ACTIVE));
        length_error = start_fire && (abort || ((bus.in_word_count % 16'd5) != 16'd0));

        take_src = start_fire ? bus.in_word_count : remaining;
        take     = (take_src >= 16'd4) ? 3'd4 : take_src[2:0];
        base     = abort ? 4'd0 : kept;

        if (group_load) begin
            for (int i = 0; i < 3; i++) byte_buf_next[i] = byte_buf[i+5];
        end

        occupancy_next = kept;
        if (append) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < take) byte_buf_next[3'(base + 4'(k))] = bus.in_data[8*k +: 8];
            end
            occupancy_next = base + 4'(take);
            remaining_next = take_src - 16'(take);
        end
        if (start_fire) packet_vc_next = bus.in_virtual_channel;

        unique case (state)
            IDLE: begin
                if (start_fire && (bus.in_word_count != 16'd0)) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (start_fire && (bus.in_word_count == 16'd0)) state_next = IDLE;
                else if (remaining == 16'd0)                    state_next = DRAIN;
            end
            DRAIN: begin
                // Whatever is left cannot form a group: the trailing partial group is dropped.
                if (occupancy < 4'd5) begin
                    state_next     = IDLE;
                    occupancy_next = 4'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            occupancy    <= 4'd0;
            remaining    <= 16'd0;
            packet_vc    <= 2'd0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_pixels_q <= 40'd0;
            out_vc_q     <= 2'd0;
        end else begin
            state     <= state_next;
            occupancy <= occupancy_next;
            remaining <= remaining_next;
            packet_vc <= packet_vc_next;
            if (group_load) begin
                out_valid_q  <= 1'b1;
                out_pixels_q <= group_pixels;
                out_last_q   <= group_last;
                out_vc_q     <= packet_vc;
            end else if (bus.out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    // NOTE: the byte buffer holds data only and is qualified by occupancy, so it needs no reset.
    always_ff @(posedge clock) begin
        byte_buf <= byte_buf_next;
    end

    assign bus.in_ready            = in_ready;
    assign bus.length_error        = length_error;
    assign bus.out_valid           = out_valid_q;
    assign bus.out_pixels          = out_pixels_q;
    assign bus.out_last            = out_last_q;
    assign bus.out_virtual_channel = out_vc_q;
endmodule

// File: tb/tb_raw10_unpacker.sv
// Self-checking bench for raw10_unpacker: directed scenarios plus random packets
// compared against a byte-level reference model of the RAW10 packing rule.
module tb_raw10_unpacker;
    typedef logic [31:0] word_q_t[$];
    typedef logic [7:0]  byte_q_t[$];

    logic clock = 1'b0;
    logic reset = 1'b1;

    raw10_unpacker_if bus ();
    raw10_unpacker dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [42:0] exp_q[$];
    logic [42:0] got_q[$];
    int          exp_rd = 0;
    int          got_rd = 0;
    int          err_seen = 0;
    int          err_exp  = 0;
    int          blocked_cycles = 0;
    int          cyc = 0;
    int          stall_from = -100;
    int          stall_len  = 0;
    bit          bp_random  = 1'b0;
    bit          pending_abort = 1'b0;
    int          wc_set[7] = '{0, 3, 5, 12, 25, 33, 60};

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Sink-side ready: optional fixed stall window and optional random backpressure.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clock);
            cyc++;
            if (cyc >= stall_from && cyc < stall_from + stall_len) bus.out_ready = 1'b0;
            else if (bp_random)                                    bus.out_ready = ($urandom_range(0, 3) != 0);
            else                                                   bus.out_ready = 1'b1;
        end
    end

    always @(negedge clock) begin
        #2;
        if (!reset) begin
            if (bus.out_valid && bus.out_ready)
                got_q.push_back({bus.out_virtual_channel, bus.out_last, bus.out_pixels});
            if (bus.length_error) err_seen++;
            if (!bus.out_ready && bus.in_valid && !bus.in_ready) blocked_cycles++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] unpack_model(input byte_q_t q, input int at);
        logic [39:0] r = '0;
        logic [39:0] pix;
        for (int n = 0; n < 4; n++) begin
            pix = 40'((int'(q[at+n]) * 4) + ((int'(q[at+4]) >> (2*n)) & 3));
            r   = r | (pix << (10*n));
        end
        return r;
    endfunction

    function automatic word_q_t random_words(input int n);
        word_q_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    function automatic int n_words(input int wc);
        return (wc == 0) ? 1 : (wc + 3) / 4;
    endfunction

    task automatic send_word(input logic [31:0] data, input bit start, input int wc, input logic [1:0] vc);
        int waited = 0;
        bus.in_data            = data;
        bus.in_start           = start;
        bus.in_word_count      = 16'(wc);
        bus.in_virtual_channel = vc;
        bus.in_valid           = 1'b1;
        #1;
        while (!bus.in_ready && waited < 500) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check("word_accepted", bus.in_ready, 1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
    endtask

    // Sends n_send words of a packet and records what the spec says must come out.
    task automatic send_packet(input int wc, input logic [1:0] vc, input word_q_t words, input int n_send);
        byte_q_t payload;
        int      full_groups = wc / 5;
        for (int i = 0; i < n_send; i++)
            for (int k = 0; k < 4; k++)
                if (4*i + k < wc) payload.push_back(words[i][8*k +: 8]);
        if (pending_abort || (wc % 5) != 0) err_exp++;
        for (int i = 0; i < n_send; i++) send_word(words[i], i == 0, wc, vc);
        for (int g = 0; g < payload.size() / 5; g++)
            exp_q.push_back({vc, g == full_groups - 1, unpack_model(payload, 5*g)});
        pending_abort = (payload.size() < wc);
    endtask

    task automatic wait_drain(input string tag);
        int w = 0;
        while (got_q.size() < exp_q.size() && w < 4000) begin
            @(negedge clock);
            w++;
        end
        repeat (12) @(negedge clock);
        check({tag, "_groups"}, 64'(got_q.size() - got_rd), 64'(exp_q.size() - exp_rd));
        for (int i = 0; i < exp_q.size() - exp_rd && i < got_q.size() - got_rd; i++) begin
            check({tag, "_pixels"}, got_q[got_rd+i][39:0],  exp_q[exp_rd+i][39:0]);
            check({tag, "_last"},   got_q[got_rd+i][40],    exp_q[exp_rd+i][40]);
            check({tag, "_vc"},     got_q[got_rd+i][42:41], exp_q[exp_rd+i][42:41]);
        end
        got_rd = got_q.size();
        exp_rd = exp_q.size();
        check({tag, "_length_error"}, err_seen, err_exp);
    endtask

    initial begin
        word_q_t words;
        int      first;
        int      blocked_before;
        int      wc;

        bus.in_valid           = 1'b0;
        bus.in_start           = 1'b0;
        bus.in_data            = '0;
        bus.in_word_count      = '0;
        bus.in_virtual_channel = '0;

        repeat (3) @(negedge clock);
        #1;
        check("reset_in_ready",     bus.in_ready, 0);
        check("reset_out_valid",    bus.out_valid, 0);
        check("reset_out_last",     bus.out_last, 0);
        check("reset_out_pixels",   bus.out_pixels, 0);
        check("reset_out_vc",       bus.out_virtual_channel, 0);
        check("reset_length_error", bus.length_error, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        @(negedge clock);

        // Single group with known bytes.
        first = got_q.size();
        words = '{32'h44332211, 32'h000000E4};
        send_packet(5, 2'd2, words, 2);
        wait_drain("single");
        check("single_known_group", got_q[first], {2'd2, 1'b1, 10'h113, 10'h0CE, 10'h089, 10'h044});

        // Padding bytes beyond the word count, then back to idle.
        send_packet(10, 2'd1, random_words(3), 3);
        wait_drain("padding");
        #1;
        check("padding_idle_ready", bus.in_ready, 1);
        @(negedge clock);

        // Output stall mid-packet.
        blocked_before = blocked_cycles;
        stall_from     = cyc + 3;
        stall_len      = 10;
        send_packet(40, 2'd3, random_words(10), 10);
        wait_drain("backpressure");
        check("backpressure_in_ready_drop", blocked_cycles > blocked_before, 1);

        // Word count not a multiple of five.
        send_packet(7, 2'd0, random_words(2), 2);
        wait_drain("bad_length");

        // Abort after two words, then a clean packet.
        send_packet(20, 2'd1, random_words(5), 2);
        send_packet(15, 2'd2, random_words(4), 4);
        wait_drain("abort");

        // Reset with three bytes buffered.
        send_packet(3, 2'd1, random_words(1), 1);
        reset = 1'b1;
        #1;
        check("midreset_in_ready",  bus.in_ready, 0);
        check("midreset_out_valid", bus.out_valid, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        pending_abort = 1'b0;
        #1;
        check("midreset_release_ready", bus.in_ready, 1);
        check("midreset_out_valid_after", bus.out_valid, 0);
        @(negedge clock);
        send_packet(15, 2'd3, random_words(4), 4);
        wait_drain("after_reset");

        // Back-to-back random packets under random backpressure.
        bp_random = 1'b1;
        for (int p = 0; p < 10; p++) begin
            wc = wc_set[$urandom_range(0, 6)];
            send_packet(wc, 2'($urandom_range(0, 3)), random_words(n_words(wc)), n_words(wc));
        end
        wait_drain("random");
        bp_random = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
